// File: rtl/camera_ctrl_if.sv
// Command/status bundle between the frame initiator (master) and camera_ctrl (slave).
interface camera_ctrl_if;
   logic Init;
   logic ExpIncrease;
   logic ExpDecrease;
   logic Erase;
   logic Expose;
   logic NRE_1;
   logic NRE_2;
   logic ADC;
   logic Busy;

   modport master (
      output Init, ExpIncrease, ExpDecrease,
      input  Erase, Expose, NRE_1, NRE_2, ADC, Busy
   );

   modport slave (
      input  Init, ExpIncrease, ExpDecrease,
      output Erase, Expose, NRE_1, NRE_2, ADC, Busy
   );
endinterface

// File: rtl/camera_ctrl.sv
// Pixel-array sequencer: erase, exposure and two-row readout with a saturating exposure register.
// Define CAM_AUTO_REPEAT_EN for level-sensitive Init with back-to-back frames from R6.
module camera_ctrl #(
   parameter int unsigned EXP_MIN = 2,
   parameter int unsigned EXP_MAX = 30,
   parameter int unsigned CNT_W   = 5
) (
   input logic          CLK,
   input logic          ResetIN,
   camera_ctrl_if.slave cam
);

   localparam logic [CNT_W-1:0] ExpMin   = CNT_W'(EXP_MIN);
   localparam logic [CNT_W-1:0] ExpMax   = CNT_W'(EXP_MAX);
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
   localparam logic [2:0]       LastStep = 3'd6;

   typedef enum logic [1:0] {StIdle, StExpose, StReadout} state_e;

   state_e           stateQ;
   logic [CNT_W-1:0] expTime;
   logic [CNT_W-1:0] expCnt;
   logic [2:0]       step;
   logic [2:0]       stepNext;
   logic             startFrame;
   logic             repeatFrame;
   logic             eraseQ, exposeQ, nre1Q, nre2Q, adcQ, busyQ;

   // Readout sub-step decode: row 1 in R0..R2, gap at R3, row 2 in R4..R6.
   function automatic logic nre1For(input logic [2:0] s);
      return !(s <= 3'd2);
   endfunction

   function automatic logic nre2For(input logic [2:0] s);
      return !(s >= 3'd4);
   endfunction

   function automatic logic adcFor(input logic [2:0] s);
      return (s == 3'd1) || (s == 3'd5);
   endfunction

`ifdef CAM_AUTO_REPEAT_EN
   assign startFrame  = cam.Init;
   assign repeatFrame = cam.Init;
`else
   logic initPrev;

   always_ff @(posedge CLK) begin
      initPrev <= cam.Init;
   end

   assign startFrame  = cam.Init & ~initPrev;
   assign repeatFrame = 1'b0;
`endif

   assign stepNext = step + 3'd1;

   always_ff @(posedge CLK) begin
      if (ResetIN) begin
         stateQ  <= StIdle;
         expTime <= ExpMin;
         expCnt  <= ExpMin;
         step    <= 3'd0;
         eraseQ  <= 1'b1;
         exposeQ <= 1'b0;
         nre1Q   <= 1'b1;
         nre2Q   <= 1'b1;
         adcQ    <= 1'b0;
         busyQ   <= 1'b0;
      end else begin
         unique case (stateQ)
            StIdle: begin
               if (startFrame) begin
                  stateQ  <= StExpose;
                  expCnt  <= expTime;
                  eraseQ  <= 1'b0;
                  exposeQ <= 1'b1;
                  busyQ   <= 1'b1;
               end else if (cam.ExpIncrease && !cam.ExpDecrease) begin
                  if (expTime < ExpMax) expTime <= expTime + CntOne;
               end else if (cam.ExpDecrease && !cam.ExpIncrease) begin
                  if (expTime > ExpMin) expTime <= expTime - CntOne;
               end
            end

            StExpose: begin
               if (expCnt == CntOne) begin
                  stateQ  <= StReadout;
                  step    <= 3'd0;
                  exposeQ <= 1'b0;
                  nre1Q   <= nre1For(3'd0);
                  nre2Q   <= nre2For(3'd0);
                  adcQ    <= adcFor(3'd0);
               end else begin
                  expCnt <= expCnt - CntOne;
               end
            end

            StReadout: begin
               if (step == LastStep) begin
                  nre1Q <= 1'b1;
                  nre2Q <= 1'b1;
                  adcQ  <= 1'b0;
                  if (repeatFrame) begin
                     // Back-to-back frame: skip IDLE, keep Erase low and Busy high.
                     stateQ  <= StExpose;
                     expCnt  <= expTime;
                     exposeQ <= 1'b1;
                  end else begin
                     stateQ <= StIdle;
                     eraseQ <= 1'b1;
                     busyQ  <= 1'b0;
                  end
               end else begin
                  step  <= stepNext;
                  nre1Q <= nre1For(stepNext);
                  nre2Q <= nre2For(stepNext);
                  adcQ  <= adcFor(stepNext);
               end
            end

            default: begin
               stateQ  <= StIdle;
               eraseQ  <= 1'b1;
               exposeQ <= 1'b0;
               nre1Q   <= 1'b1;
               nre2Q   <= 1'b1;
               adcQ    <= 1'b0;
               busyQ   <= 1'b0;
            end
         endcase
      end
   end

   assign cam.Erase  = eraseQ;
   assign cam.Expose = exposeQ;
   assign cam.NRE_1  = nre1Q;
   assign cam.NRE_2  = nre2Q;
   assign cam.ADC    = adcQ;
   assign cam.Busy   = busyQ;

   nreExclusive: assert property (@(posedge CLK) disable iff (ResetIN) (nre1Q || nre2Q));

   adcOnlyInConvert: assert property (@(posedge CLK) disable iff (ResetIN)
      adcQ |-> (stateQ == StReadout && (step == 3'd1 || step == 3'd5)));

   expTimeInRange: assert property (@(posedge CLK) disable iff (ResetIN)
      (expTime >= ExpMin && expTime <= ExpMax));

   busyMatchesState: assert property (@(posedge CLK) disable iff (ResetIN)
      (busyQ == (stateQ != StIdle)));

endmodule

// File: tb/tb_camera_ctrl.sv
// Cycle scoreboard for camera_ctrl: a frame-timeline model predicts every output vector.
module tb_camera_ctrl;

`ifdef CAM_AUTO_REPEAT_EN
   localparam bit AutoRepeat = 1'b1;
`else
   localparam bit AutoRepeat = 1'b0;
`endif

   logic CLK = 1'b0;
   logic ResetIN;

   camera_ctrl_if cam ();

   camera_ctrl #(
      .EXP_MIN (2),
      .EXP_MAX (30),
      .CNT_W   (5)
   ) dut (
      .CLK     (CLK),
      .ResetIN (ResetIN),
      .cam     (cam.slave)
   );

   always #5 CLK = ~CLK;

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;
   string       phase = "reset";

   logic [5:0] expQ[$];

   // Model state: frame timeline position rather than a state machine.
   int  mExp = 2;
   int  mFrameExp = 2;
   int  mT = 0;
   int  mStarts = 0;
   bit  mActive = 1'b0;
   bit  mPrevInit = 1'b0;
   int  exposeRises = 0;
   logic exposePrev = 1'b0;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic modelStep(input bit r, input bit init, input bit inc, input bit dec);
      bit start;
      if (r) begin
         mExp    = 2;
         mActive = 1'b0;
         mT      = 0;
      end else if (mActive) begin
         mT++;
         if (mT == mFrameExp + 7) begin
            if (AutoRepeat && init) begin
               mT        = 0;
               mFrameExp = mExp;
               mStarts++;
            end else begin
               mActive = 1'b0;
            end
         end
      end else begin
         start = AutoRepeat ? init : (init && !mPrevInit);
         if (start) begin
            mActive   = 1'b1;
            mT        = 0;
            mFrameExp = mExp;
            mStarts++;
         end else if (inc && !dec) begin
            if (mExp < 30) mExp++;
         end else if (dec && !inc) begin
            if (mExp > 2) mExp--;
         end
      end
      mPrevInit = init;
   endtask

   // {Erase, Expose, NRE_1, NRE_2, ADC, Busy}
   function automatic logic [5:0] modelVec();
      int r;
      if (!mActive) return 6'b1_0_1_1_0_0;
      if (mT < mFrameExp) return 6'b0_1_1_1_0_1;
      r = mT - mFrameExp;
      return {1'b0, 1'b0, !(r <= 2), !(r >= 4), (r == 1 || r == 5), 1'b1};
   endfunction

   task automatic drive(input bit r, input bit init, input bit inc, input bit dec, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         ResetIN         = r;
         cam.Init        = init;
         cam.ExpIncrease = inc;
         cam.ExpDecrease = dec;
         modelStep(r, init, inc, dec);
         expQ.push_back(modelVec());
      end
   endtask

   always @(posedge CLK) begin
      logic [5:0] want;
      logic [5:0] got;
      #1;
      got = {cam.Erase, cam.Expose, cam.NRE_1, cam.NRE_2, cam.ADC, cam.Busy};
      if (cam.Expose === 1'b1 && exposePrev !== 1'b1) exposeRises++;
      exposePrev = cam.Expose;
      if (expQ.size() != 0) begin
         want = expQ.pop_front();
         checkEq(phase, {26'd0, got}, {26'd0, want});
      end
   end

   initial begin
      int rises0;
      int starts0;
      ResetIN         = 1'b1;
      cam.Init        = 1'b0;
      cam.ExpIncrease = 1'b0;
      cam.ExpDecrease = 1'b0;

      phase = "reset";      drive(1, 0, 0, 0, 3);
      phase = "idleAfterRst"; drive(0, 0, 0, 0, 4);

      phase = "frameExp2";  drive(0, 1, 0, 0, 1); drive(0, 0, 0, 0, 12);

      phase = "inc5Frame";  drive(0, 0, 1, 0, 5); drive(0, 1, 0, 0, 1); drive(0, 0, 0, 0, 16);

      phase = "incSat";     drive(0, 0, 1, 0, 40); drive(0, 1, 0, 0, 1); drive(0, 0, 0, 0, 40);
      phase = "decSat";     drive(0, 0, 0, 1, 40); drive(0, 1, 0, 0, 1); drive(0, 0, 0, 0, 12);
      phase = "bothHeld";   drive(0, 0, 1, 0, 3); drive(0, 0, 1, 1, 5);
      drive(0, 1, 0, 0, 1); drive(0, 0, 0, 0, 14);

      phase = "initPrio";   drive(0, 1, 1, 0, 1); drive(0, 0, 0, 0, 14);

      phase = "incInExpose"; drive(0, 1, 0, 0, 1); drive(0, 0, 1, 0, 8); drive(0, 0, 0, 0, 6);
      drive(0, 1, 0, 0, 1); drive(0, 0, 0, 0, 14);

      phase = "rstMidExpose"; drive(0, 0, 1, 0, 10); drive(0, 1, 0, 0, 1); drive(0, 0, 0, 0, 3);
      drive(1, 0, 0, 0, 1); drive(0, 0, 0, 0, 3); drive(0, 1, 0, 0, 1); drive(0, 0, 0, 0, 12);

      phase   = "initHeld";
      rises0  = exposeRises;
      starts0 = mStarts;
      drive(0, 1, 0, 0, 30); drive(0, 0, 0, 0, 20);
      @(posedge CLK); #2;
      checkEq("heldInitFrames", exposeRises - rises0, mStarts - starts0);
      checkEq("heldInitFloor", (mStarts - starts0 >= 1), 1);

      phase = "random";
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 1);
      end
      drive(0, 0, 0, 0, 40);

      @(posedge CLK); #2;
      checkEq("queueDrained", expQ.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
